vma_multi_brk: RTL and testbench

- Parametrised successor to the EBOX VMA board logic.
- Holds the VMA, PC, VMA HELD and previous-section registers, and computes the next VMA: load, +1, +magic, or PC+magic.
- Extended-mode increment honours the local/global section wrap.
- Adds N independent address-break channels with per-channel access-type masks and sticky hit flags.
- Sits between EDP (AD bus), CON/MCL (control) and PAG/CSH (consumers of VMA and AC_REF).

---
 rtl/vma_pkg.sv | 19 +
 rtl/vma_brk_chan.sv | 61 ++++++
 rtl/vma_multi_brk.sv | 114 +++++++++++
 tb/tb_vma_multi_brk.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vma_pkg.sv
// Shared types and constants for the VMA board and its address-break channels.
// The optional per-channel hit counters are enabled with VMA_BRK_COUNT_EN.
package vma_pkg;
  localparam int IN_SECTION_W = 18;
  localparam int COUNT_W      = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    INC   = 2'b10,
    MAGIC = 2'b11
  } vma_op_t;

  typedef struct packed {
    logic fetch;
    logic write;
    logic read;
  } brk_mask_t;
endpackage

// File: rtl/vma_brk_chan.sv
// One address-break channel: address/mask registers, comparator and sticky hit flag.
// With VMA_BRK_COUNT_EN defined, also keeps an 8-bit saturating hit counter.
module vma_brk_chan
  import vma_pkg::*;
#(
  parameter int VMA_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [VMA_W-1:0] wr_addr,
  input  logic [2:0]       wr_mask,
  input  logic             clr,
  input  logic             acc_valid,
  input  logic             acc_read,
  input  logic             acc_write,
  input  logic             acc_fetch,
  input  logic [VMA_W-1:0] vma,
  output logic             hit_next,
  output logic             hit
`ifdef VMA_BRK_COUNT_EN
  ,
  output logic [COUNT_W-1:0] count
`endif
);
  logic [VMA_W-1:0] addr;
  brk_mask_t        mask;
  logic             match;

  assign match = acc_valid && (addr == vma) &&
                 ((acc_read && mask.read) || (acc_write && mask.write) ||
                  (acc_fetch && mask.fetch));

  // A new match outranks a clear in the same cycle.
  assign hit_next = match | (hit & ~clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      mask <= '0;
      hit  <= 1'b0;
    end else begin
      if (wr) begin
        addr <= wr_addr;
        mask <= brk_mask_t'(wr_mask);
      end
      hit <= hit_next;
    end
  end

`ifdef VMA_BRK_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= match ? COUNT_W'(1) : '0;
    else if (match && (count != '1))
      count <= count + COUNT_W'(1);
  end
`endif
endmodule

// File: rtl/vma_multi_brk.sv
// EBOX VMA/PC/HELD/previous-section registers, next-VMA arithmetic and N address-break channels.
// Define VMA_BRK_COUNT_EN to add per-channel saturating hit counters on brk_count.
module vma_multi_brk
  import vma_pkg::*;
#(
  parameter int VMA_W   = 24,
  parameter int SEC_W   = 6,
  parameter int N_BRK   = 4,
  parameter int MAGIC_W = 9,
  localparam int IDX_W  = (N_BRK > 1) ? $clog2(N_BRK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         vma_op,
  input  logic               vma_src_ad,
  input  logic               global_mode,
  input  logic [VMA_W-1:0]   ad,
  input  logic [MAGIC_W-1:0] magic,
  input  logic               load_pc,
  input  logic               load_held,
  input  logic               sel_held,
  input  logic               load_prev_sec,
  input  logic               acc_valid,
  input  logic               acc_read,
  input  logic               acc_write,
  input  logic               acc_fetch,
  input  logic               brk_wr,
  input  logic [IDX_W-1:0]   brk_idx,
  input  logic [VMA_W-1:0]   brk_addr,
  input  logic [2:0]         brk_mask,
  input  logic [N_BRK-1:0]   brk_clr,
  output logic [VMA_W-1:0]   vma,
  output logic [VMA_W-1:0]   pc,
  output logic [VMA_W-1:0]   held,
  output logic [VMA_W-1:0]   held_or_pc,
  output logic [SEC_W-1:0]   prev_sec,
  output logic               vma_sec0,
  output logic               pc_sec0,
  output logic               ac_ref,
  output logic [N_BRK-1:0]   brk_hit,
  output logic               brk_any
`ifdef VMA_BRK_COUNT_EN
  ,
  output logic [N_BRK*COUNT_W-1:0] brk_count
`endif
);
  vma_op_t          op;
  logic [VMA_W-1:0] base, off, sum_glob, sum_loc, vma_nxt;
  logic [N_BRK-1:0] hit_next;

  assign op = vma_op_t'(vma_op);

  always_comb begin
    base     = (op == MAGIC && !vma_src_ad) ? pc : vma;
    off      = (op == INC) ? VMA_W'(1) : {{(VMA_W-MAGIC_W){magic[MAGIC_W-1]}}, magic};
    sum_glob = base + off;
    // Local addressing wraps inside the section; the section field is untouched.
    sum_loc  = {base[VMA_W-1:IN_SECTION_W],
                base[IN_SECTION_W-1:0] + off[IN_SECTION_W-1:0]};
    vma_nxt  = vma;
    case (op)
      LOAD:       vma_nxt = vma_src_ad ? ad : pc;
      INC, MAGIC: vma_nxt = global_mode ? sum_glob : sum_loc;
      default:    vma_nxt = vma;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vma      <= '0;
      pc       <= '0;
      held     <= '0;
      prev_sec <= '0;
      brk_any  <= 1'b0;
    end else begin
      vma <= vma_nxt;
      if (load_pc)       pc       <= vma;
      if (load_held)     held     <= vma;
      if (load_prev_sec) prev_sec <= ad[VMA_W-1:IN_SECTION_W];
      brk_any <= |hit_next;
    end
  end

  assign held_or_pc = sel_held ? held : pc;
  assign vma_sec0   = (vma[VMA_W-1:IN_SECTION_W] == '0);
  assign pc_sec0    = (pc[VMA_W-1:IN_SECTION_W] == '0);

  // AC reference: in-section address 0..17 (octal), in section 0 or under a local/fetch context.
  assign ac_ref = acc_valid && (acc_read || acc_write) &&
                  (vma[IN_SECTION_W-1:4] == '0) &&
                  (vma_sec0 || !global_mode || acc_fetch);

  for (genvar i = 0; i < N_BRK; i++) begin : g_chan
    vma_brk_chan #(.VMA_W(VMA_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (brk_wr && (brk_idx == IDX_W'(i))),
      .wr_addr   (brk_addr),
      .wr_mask   (brk_mask),
      .clr       (brk_clr[i]),
      .acc_valid (acc_valid),
      .acc_read  (acc_read),
      .acc_write (acc_write),
      .acc_fetch (acc_fetch),
      .vma       (vma),
      .hit_next  (hit_next[i]),
      .hit       (brk_hit[i])
`ifdef VMA_BRK_COUNT_EN
      ,
      .count     (brk_count[i*COUNT_W +: COUNT_W])
`endif
    );
  end
endmodule

// File: tb/tb_vma_multi_brk.sv
// Randomised plus directed bench for vma_multi_brk with a queue-based scoreboard.
// Counter checks are active when VMA_BRK_COUNT_EN is defined.
module tb_vma_multi_brk;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  vma_op;
  logic        vma_src_ad, global_mode;
  logic [23:0] ad;
  logic [8:0]  magic;
  logic        load_pc, load_held, sel_held, load_prev_sec;
  logic        acc_valid, acc_read, acc_write, acc_fetch;
  logic        brk_wr;
  logic [1:0]  brk_idx;
  logic [23:0] brk_addr;
  logic [2:0]  brk_mask;
  logic [3:0]  brk_clr;
  logic [23:0] vma, pc, held, held_or_pc;
  logic [5:0]  prev_sec;
  logic        vma_sec0, pc_sec0, ac_ref;
  logic [3:0]  brk_hit;
  logic        brk_any;
`ifdef VMA_BRK_COUNT_EN
  logic [31:0] brk_count;
`endif

  always #5 clk = ~clk;

  vma_multi_brk #(.VMA_W(24), .SEC_W(6), .N_BRK(4), .MAGIC_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .vma_op(vma_op), .vma_src_ad(vma_src_ad),
    .global_mode(global_mode), .ad(ad), .magic(magic), .load_pc(load_pc),
    .load_held(load_held), .sel_held(sel_held), .load_prev_sec(load_prev_sec),
    .acc_valid(acc_valid), .acc_read(acc_read), .acc_write(acc_write),
    .acc_fetch(acc_fetch), .brk_wr(brk_wr), .brk_idx(brk_idx), .brk_addr(brk_addr),
    .brk_mask(brk_mask), .brk_clr(brk_clr), .vma(vma), .pc(pc), .held(held),
    .held_or_pc(held_or_pc), .prev_sec(prev_sec), .vma_sec0(vma_sec0),
    .pc_sec0(pc_sec0), .ac_ref(ac_ref), .brk_hit(brk_hit), .brk_any(brk_any)
`ifdef VMA_BRK_COUNT_EN
    , .brk_count(brk_count)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  op;
    logic        src_ad, glob;
    logic [23:0] ad;
    logic [8:0]  magic;
    logic        lpc, lheld, sel, lprev;
    logic        av, rd, wr, fe;
    logic        bwr;
    logic [1:0]  bidx;
    logic [23:0] baddr;
    logic [2:0]  bmask;
    logic [3:0]  bclr;
  } stim_t;

  typedef struct {
    logic [23:0] vma, pc, held, hop;
    logic [5:0]  prev;
    logic        s0, p0, acr;
    logic [3:0]  hit;
    logic        any;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state, described directly from the architectural rules.
  longint m_vma, m_pc, m_held, m_prev;
  longint m_baddr[4];
  logic [2:0] m_bmask[4];
  logic [3:0] m_hit;
  int m_cnt[4];

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, op: 2'd0, src_ad: 1'b0, glob: 1'b0, ad: 24'd0, magic: 9'd0,
          lpc: 1'b0, lheld: 1'b0, sel: 1'b0, lprev: 1'b0, av: 1'b0, rd: 1'b0,
          wr: 1'b0, fe: 1'b0, bwr: 1'b0, bidx: 2'd0, baddr: 24'd0, bmask: 3'd0,
          bclr: 4'd0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst_n = s.rst_n; vma_op = s.op; vma_src_ad = s.src_ad; global_mode = s.glob;
    ad = s.ad; magic = s.magic; load_pc = s.lpc; load_held = s.lheld;
    sel_held = s.sel; load_prev_sec = s.lprev; acc_valid = s.av; acc_read = s.rd;
    acc_write = s.wr; acc_fetch = s.fe; brk_wr = s.bwr; brk_idx = s.bidx;
    brk_addr = s.baddr; brk_mask = s.bmask; brk_clr = s.bclr;
  endtask

  task automatic step(input stim_t s);
    exp_t   e;
    longint base, off, nv;
    logic   m;
    @(negedge clk);
    drive(s);
    if (!s.rst_n) begin
      m_vma = 0; m_pc = 0; m_held = 0; m_prev = 0; m_hit = 4'd0;
      for (int i = 0; i < 4; i++) begin m_baddr[i] = 0; m_bmask[i] = 3'd0; m_cnt[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m = s.av && (m_baddr[i] == m_vma) &&
            ((s.rd && m_bmask[i][0]) || (s.wr && m_bmask[i][1]) || (s.fe && m_bmask[i][2]));
        if (s.bclr[i]) m_cnt[i] = m ? 1 : 0;
        else if (m)    m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
        m_hit[i] = m || (m_hit[i] && !s.bclr[i]);
      end
      off  = (s.op == 2'd2) ? 1 : (s.magic[8] ? longint'(s.magic) - 512 : longint'(s.magic));
      base = (s.op == 2'd3 && !s.src_ad) ? m_pc : m_vma;
      case (s.op)
        2'd1:    nv = s.src_ad ? longint'(s.ad) : m_pc;
        2'd2,
        2'd3:    nv = s.glob ? ((base + off) % (64'd1 << 24) + (64'd1 << 24)) % (64'd1 << 24)
                             : (base / 262144) * 262144 + ((base % 262144) + off + 262144) % 262144;
        default: nv = m_vma;
      endcase
      if (s.lpc)   m_pc   = m_vma;
      if (s.lheld) m_held = m_vma;
      if (s.lprev) m_prev = longint'(s.ad) / 262144;
      if (s.bwr) begin m_baddr[s.bidx] = longint'(s.baddr); m_bmask[s.bidx] = s.bmask; end
      m_vma = nv;
    end
    e.vma  = 24'(m_vma);
    e.pc   = 24'(m_pc);
    e.held = 24'(m_held);
    e.hop  = s.sel ? 24'(m_held) : 24'(m_pc);
    e.prev = 6'(m_prev);
    e.s0   = (m_vma < 262144);
    e.p0   = (m_pc < 262144);
    e.acr  = s.av && (s.rd || s.wr) && ((m_vma % 262144) < 16) &&
             ((m_vma < 262144) || !s.glob || s.fe);
    e.hit  = m_hit;
    e.any  = (m_hit != 4'd0);
    e.cnt  = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0o expected %0o", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("vma", 32'(vma), 32'(e.vma));
      chk("pc", 32'(pc), 32'(e.pc));
      chk("held", 32'(held), 32'(e.held));
      chk("held_or_pc", 32'(held_or_pc), 32'(e.hop));
      chk("prev_sec", 32'(prev_sec), 32'(e.prev));
      chk("vma_sec0", 32'(vma_sec0), 32'(e.s0));
      chk("pc_sec0", 32'(pc_sec0), 32'(e.p0));
      chk("ac_ref", 32'(ac_ref), 32'(e.acr));
      chk("brk_hit", 32'(brk_hit), 32'(e.hit));
      chk("brk_any", 32'(brk_any), 32'(e.any));
`ifdef VMA_BRK_COUNT_EN
      chk("brk_count", brk_count, e.cnt);
`endif
    end
  end

  function automatic logic [23:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 24'o100;
      1: return 24'o17;
      2: return 24'o777777;
      3: return 24'o3777777;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    stim_t s;
    drive(idle());
    rst_n = 1'b0;

    // Reset, then build up state and clear it with strobes still asserted.
    s = idle(); s.rst_n = 1'b0; step(s); step(s);
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o123456;
    s.bwr = 1'b1; s.bidx = 2'd0; s.baddr = 24'o123456; s.bmask = 3'b001; step(s);
    s = idle(); s.lpc = 1'b1; s.lheld = 1'b1; s.lprev = 1'b1; s.ad = 24'o77000000;
    s.av = 1'b1; s.rd = 1'b1; step(s);
    s = idle(); s.sel = 1'b1; step(s);
    s = idle(); s.rst_n = 1'b0; s.lpc = 1'b1; s.lheld = 1'b1; s.lprev = 1'b1;
    s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o777; step(s);

    // Local versus global section wrap on increment.
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o3777777; step(s);
    s = idle(); s.op = 2'd2; s.glob = 1'b0; step(s);
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o3777777; step(s);
    s = idle(); s.op = 2'd2; s.glob = 1'b1; step(s);
    s = idle(); s.lpc = 1'b1; step(s);

    // PC + magic with a negative offset.
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o1000; step(s);
    s = idle(); s.lpc = 1'b1; step(s);
    s = idle(); s.op = 2'd3; s.src_ad = 1'b0; s.magic = 9'o776; step(s);

    // Write-only break on channel 2, plus a disabled (mask 000) channel 3 on the same address.
    s = idle(); s.bwr = 1'b1; s.bidx = 2'd2; s.baddr = 24'o100; s.bmask = 3'b010; step(s);
    s = idle(); s.bwr = 1'b1; s.bidx = 2'd3; s.baddr = 24'o100; s.bmask = 3'b000;
    s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o100; step(s);
    s = idle(); s.av = 1'b1; s.rd = 1'b1; s.fe = 1'b1; step(s);
    s = idle(); s.av = 1'b1; s.wr = 1'b1; step(s);
    s = idle(); step(s); step(s);
    s = idle(); s.bwr = 1'b1; s.bidx = 2'd2; s.baddr = 24'o200; s.bmask = 3'b010; step(s);
    s = idle(); s.bwr = 1'b1; s.bidx = 2'd2; s.baddr = 24'o100; s.bmask = 3'b010; step(s);
    s = idle(); s.bclr = 4'b0100; s.av = 1'b1; s.wr = 1'b1; step(s);
    s = idle(); s.bclr = 4'b0100; step(s);
    s = idle(); step(s);

    // AC reference qualification.
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o17; s.av = 1'b1; s.rd = 1'b1;
    s.glob = 1'b1; step(s);
    s = idle(); s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o2000017; s.av = 1'b1; s.rd = 1'b1;
    s.glob = 1'b1; step(s);
    s = idle(); s.av = 1'b1; s.rd = 1'b1; s.glob = 1'b1; s.fe = 1'b1; step(s);
    s = idle(); s.av = 1'b1; s.wr = 1'b1; s.glob = 1'b0; step(s);

    // Counter saturation: 300 matching reads on channel 0, then clear with a match.
    s = idle(); s.bwr = 1'b1; s.bidx = 2'd0; s.baddr = 24'o500; s.bmask = 3'b001;
    s.op = 2'd1; s.src_ad = 1'b1; s.ad = 24'o500; step(s);
    s = idle(); s.av = 1'b1; s.rd = 1'b1;
    for (int i = 0; i < 300; i++) step(s);
    s.bclr = 4'b0001; step(s);
    s = idle(); s.bclr = 4'b0001; step(s);

    // Randomised traffic over a small address pool so breaks fire often.
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rst_n  = ($urandom_range(0, 99) != 0);
      s.op     = 2'($urandom_range(0, 3));
      s.src_ad = 1'($urandom);
      s.glob   = 1'($urandom);
      s.ad     = pick_addr();
      s.magic  = 9'($urandom);
      s.lpc    = 1'($urandom);
      s.lheld  = 1'($urandom);
      s.sel    = 1'($urandom);
      s.lprev  = 1'($urandom);
      s.av     = 1'($urandom);
      s.rd     = 1'($urandom);
      s.wr     = 1'($urandom);
      s.fe     = 1'($urandom);
      s.bwr    = ($urandom_range(0, 3) == 0);
      s.bidx   = 2'($urandom);
      s.baddr  = pick_addr();
      s.bmask  = 3'($urandom);
      s.bclr   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      step(s);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
